// File: rtl/interval_timer_pkg.sv
// rtl/interval_timer_pkg.sv - shared types and defaults for the interval timer controller
//
// Purpose : FSM state encoding and default counter width used by the
//           interval timer controller and its counter datapath.
// Contents: NUM_BITS_DEFAULT - default counter/limit width
//           state_t          - ST_IDLE / ST_RUN / ST_PAUSED
package interval_timer_pkg;

    localparam int NUM_BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

endpackage

// File: rtl/counter_core.sv
// rtl/counter_core.sv - binary up-counter with synchronous clear and enable
//
// Purpose : NUM_BITS-wide counter stepped by the interval timer controller.
// Ports   : clk   - clock, all logic on posedge
//           reset - synchronous active-high reset, value -> 0
//           en    - count up by one this edge
//           clr   - force value to 0 this edge (wins over en)
//           value - current count (registered)
module counter_core #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    output logic [NUM_BITS-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= '0;
        end else if (en) begin
            value <= value + NUM_BITS'(1);
        end
    end

endmodule

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - programmable one-shot/periodic interval timer controller
//
// Purpose : Sequences counter_core as an interval timer. start latches the
//           terminal value and mode, hold pauses, abort stops. A one-cycle
//           expire pulse marks each terminal count.
// Ports   : clk      - clock, all logic on posedge
//           reset    - synchronous active-high reset
//           start    - start/restart strobe, latches limit and periodic
//           abort    - stop immediately and return to idle
//           hold     - level, freezes counting while running
//           periodic - mode sampled with start: 1 auto-reload, 0 one-shot
//           limit    - terminal count, sampled with start
//           count    - current counter value (registered)
//           busy     - high while running or paused (registered)
//           expire   - one-cycle pulse on terminal count (registered)
module interval_timer_ctrl
    import interval_timer_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                hold,
    input  logic                periodic,
    input  logic [NUM_BITS-1:0] limit,
    output logic [NUM_BITS-1:0] count,
    output logic                busy,
    output logic                expire
);

    state_t              state;
    logic [NUM_BITS-1:0] limit_q;
    logic                mode_q;
    logic                terminal;
    logic                run_step;
    logic                cnt_en;
    logic                cnt_clr;

    assign terminal = (count == limit_q);

    // A counting edge is one spent in RUN with hold low; the resume edge out
    // of PAUSED is deliberately not one of them.
    assign run_step = (state == ST_RUN) && !hold;

    // The terminal edge clears instead of incrementing, so the counter never
    // relies on natural overflow, even with limit_q at full range.
    assign cnt_en  = run_step && !terminal;
    assign cnt_clr = abort || start || (run_step && terminal);

    counter_core #(
        .NUM_BITS (NUM_BITS)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .value (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            expire  <= 1'b0;
            limit_q <= '0;
            mode_q  <= 1'b0;
        end else if (abort) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            expire <= 1'b0;
        end else if (start) begin
            // Restart wins over a terminal edge, so no expire is issued here.
            state   <= ST_RUN;
            busy    <= 1'b1;
            expire  <= 1'b0;
            limit_q <= limit;
            mode_q  <= periodic;
        end else begin
            expire <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                end
                ST_RUN: begin
                    if (hold) begin
                        state <= ST_PAUSED;
                    end else if (terminal) begin
                        expire <= 1'b1;
                        if (!mode_q) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!hold) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb/tb_interval_timer_ctrl.sv - self-checking bench for interval_timer_ctrl
module tb_interval_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, abort, hold, periodic;
    logic [3:0] limit;
    logic [3:0] count;
    logic       busy, expire;

    int checks = 0;
    int passed = 0;

    // Reference model: timer described by its externally visible rules.
    int m_cnt, m_lim;
    bit m_busy, m_paused, m_exp, m_per;

    interval_timer_ctrl #(.NUM_BITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .hold     (hold),
        .periodic (periodic),
        .limit    (limit),
        .count    (count),
        .busy     (busy),
        .expire   (expire)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        if (reset) begin
            m_cnt = 0; m_lim = 0; m_per = 0; m_busy = 0; m_paused = 0; m_exp = 0;
        end else if (abort) begin
            m_cnt = 0; m_busy = 0; m_paused = 0; m_exp = 0;
        end else if (start) begin
            m_lim = int'(limit); m_per = periodic; m_cnt = 0;
            m_busy = 1; m_paused = 0; m_exp = 0;
        end else begin
            m_exp = 0;
            if (m_busy && m_paused) begin
                if (!hold) m_paused = 0;
            end else if (m_busy && hold) begin
                m_paused = 1;
            end else if (m_busy) begin
                if (m_cnt == m_lim) begin
                    m_cnt = 0;
                    m_exp = 1;
                    if (!m_per) m_busy = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; abort = 0; hold = 0; periodic = 0; limit = 4'd0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            reset = 1;
            start = 1'($urandom); abort = 1'($urandom); hold = 1'($urandom);
            periodic = 1'($urandom); limit = 4'($urandom);
            tick();
            checks++;
            if (count !== 4'd0 || busy !== 1'b0 || expire !== 1'b0)
                $display("FAIL reset cyc=%0d got cnt=%0d busy=%0b exp=%0b want 0/0/0", i, count, busy, expire);
            else passed++;
        end
        idle_inputs();
        tick();
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || expire !== 1'b0)
            $display("FAIL reset_release got cnt=%0d busy=%0b exp=%0b want 0/0/0", count, busy, expire);
        else passed++;
    endtask

    task automatic test_one_shot();
        int want_cnt[4] = '{1, 2, 3, 0};
        bit want_e[4]   = '{0, 0, 0, 1};
        bit want_b[4]   = '{1, 1, 1, 0};
        start = 1; limit = 4'd3; periodic = 0;
        tick();
        start = 0; limit = 4'd9; periodic = 1;
        checks++;
        if (count !== 4'd0 || busy !== 1'b1 || expire !== 1'b0)
            $display("FAIL one_shot_start got cnt=%0d busy=%0b exp=%0b want 0/1/0", count, busy, expire);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count !== 4'(want_cnt[i]) || busy !== want_b[i] || expire !== want_e[i])
                $display("FAIL one_shot edge=%0d got cnt=%0d busy=%0b exp=%0b want %0d/%0b/%0b",
                         i + 1, count, busy, expire, want_cnt[i], want_b[i], want_e[i]);
            else passed++;
        end
        tick();
        checks++;
        if (expire !== 1'b0 || busy !== 1'b0)
            $display("FAIL one_shot_after got busy=%0b exp=%0b want 0/0", busy, expire);
        else passed++;
    endtask

    task automatic test_periodic();
        start = 1; limit = 4'd2; periodic = 1;
        tick();
        start = 0; limit = 4'd7; periodic = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (count !== 4'(i % 3) || busy !== 1'b1 || expire !== (i % 3 == 0))
                $display("FAIL periodic edge=%0d got cnt=%0d busy=%0b exp=%0b want %0d/1/%0b",
                         i, count, busy, expire, i % 3, (i % 3 == 0));
            else passed++;
        end
        abort = 1;
        tick();
        abort = 0;
    endtask

    task automatic test_hold();
        int  edges = 2;
        bit  seen  = 0;
        start = 1; limit = 4'd5; periodic = 1;
        tick();
        start = 0;
        tick(); tick();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            edges++;
            checks++;
            if (count !== 4'd2 || busy !== 1'b1 || expire !== 1'b0)
                $display("FAIL hold_frozen cyc=%0d got cnt=%0d busy=%0b exp=%0b want 2/1/0", i, count, busy, expire);
            else passed++;
        end
        hold = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            edges++;
            if (expire === 1'b1) seen = 1;
        end
        // 6 edges of interval + 3 held edges + 1 resume edge
        checks++;
        if (!seen || edges != 10)
            $display("FAIL hold_delay got expire_edge=%0d seen=%0b want 10", edges, seen);
        else passed++;
        abort = 1;
        tick();
        abort = 0;
    endtask

    task automatic test_restart();
        start = 1; limit = 4'd4; periodic = 1;
        tick();
        start = 0;
        for (int i = 0; i < 4; i++) tick();
        start = 1; limit = 4'd1; periodic = 1;
        tick();
        start = 0; limit = 4'd12;
        checks++;
        if (count !== 4'd0 || busy !== 1'b1 || expire !== 1'b0)
            $display("FAIL restart_edge got cnt=%0d busy=%0b exp=%0b want 0/1/0", count, busy, expire);
        else passed++;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (count !== 4'(i % 2) || expire !== (i % 2 == 0))
                $display("FAIL restart_period edge=%0d got cnt=%0d exp=%0b want %0d/%0b",
                         i, count, expire, i % 2, (i % 2 == 0));
            else passed++;
        end
        abort = 1;
        tick();
        abort = 0;
    endtask

    task automatic test_abort();
        start = 1; limit = 4'd15; periodic = 0;
        tick();
        start = 0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (count !== 4'd6)
            $display("FAIL abort_pre got cnt=%0d want 6", count);
        else passed++;
        abort = 1;
        tick();
        abort = 0;
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || expire !== 1'b0)
            $display("FAIL abort got cnt=%0d busy=%0b exp=%0b want 0/0/0", count, busy, expire);
        else passed++;
        start = 1; limit = 4'd0; periodic = 0;
        tick();
        start = 0;
        tick();
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || expire !== 1'b1)
            $display("FAIL limit0_one_shot got cnt=%0d busy=%0b exp=%0b want 0/0/1", count, busy, expire);
        else passed++;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) < 1);
            abort    = ($urandom_range(0, 99) < 3);
            start    = ($urandom_range(0, 99) < 8);
            hold     = ($urandom_range(0, 99) < 20);
            periodic = 1'($urandom);
            limit    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 1) * 15) : 4'($urandom);
            tick();
            checks++;
            if (count !== 4'(m_cnt) || busy !== m_busy || expire !== m_exp) begin
                if (bad < 10)
                    $display("FAIL random cyc=%0d got cnt=%0d busy=%0b exp=%0b want %0d/%0b/%0b",
                             i, count, busy, expire, m_cnt, m_busy, m_exp);
                bad++;
            end else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_model_sync();
        // Directed scenarios leave the model tracking too; confirm agreement.
        checks++;
        if (count !== 4'(m_cnt) || busy !== m_busy || expire !== m_exp)
            $display("FAIL model_sync got cnt=%0d busy=%0b exp=%0b want %0d/%0b/%0b",
                     count, busy, expire, m_cnt, m_busy, m_exp);
        else passed++;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        m_cnt = 0; m_lim = 0; m_per = 0; m_busy = 0; m_paused = 0; m_exp = 0;
        test_reset();
        test_one_shot();
        test_model_sync();
        test_periodic();
        test_hold();
        test_model_sync();
        test_restart();
        test_abort();
        test_model_sync();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
